uart_rx: RTL and testbench

- Serial receiver that consumes the TX_OUT stream of the UART transmitter and rebuilds the parallel byte.
- Frame format: start bit, 8 data bits LSB-first, optional parity bit, 1 stop bit.
- Runs on an oversampling clock, with 8, 16 or 32 clocks per bit. Each bit value is a majority vote of three mid-bit samples.
- Delivers the byte with a one-cycle data_valid pulse, and flags parity and stop errors.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_rx_if.sv | 25 ++
 rtl/uart_rx_sampler.sv | 46 ++++
 rtl/uart_rx.sv | 112 +++++++++++
 tb/tb_uart_rx.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receiver types, constants and helpers
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int unsigned PRESC_8  = 8;
  localparam int unsigned PRESC_16 = 16;
  localparam int unsigned PRESC_32 = 32;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  function automatic logic presc_ok(input int unsigned p);
    return (p == PRESC_8) || (p == PRESC_16) || (p == PRESC_32);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line, frame configuration and received-byte outputs
interface uart_rx_if #(
  parameter int DATA_W  = 8,
  parameter int PRESC_W = 6
);
  logic               RX_IN;
  logic [PRESC_W-1:0] prescale;
  logic               PAR_EN;
  logic               PAR_TYP;
  logic [DATA_W-1:0]  P_DATA;
  logic               data_valid;
  logic               par_err;
  logic               stp_err;
  logic               busy;

  modport master (
    output RX_IN, prescale, PAR_EN, PAR_TYP,
    input  P_DATA, data_valid, par_err, stp_err, busy
  );

  modport slave (
    input  RX_IN, prescale, PAR_EN, PAR_TYP,
    output P_DATA, data_valid, par_err, stp_err, busy
  );
endinterface

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - per-bit edge counter with three-sample mid-bit majority vote
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int PRESC_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_s,
  input  logic [PRESC_W-1:0] p,
  input  logic               en,
  input  logic               restart,
  output logic               bit_val,
  output logic               bit_end
);

  localparam logic [PRESC_W-1:0] ONE = PRESC_W'(1);

  logic [PRESC_W-1:0] edge_cnt;
  logic [PRESC_W-1:0] half;
  logic [2:0]         smp;

  assign half    = p >> 1;
  assign bit_end = en && (edge_cnt == p - ONE);
  assign bit_val = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);

  always_ff @(posedge clk) begin
    if (rst) begin
      edge_cnt <= '0;
      smp      <= '1;
    end else begin
      if (restart) begin
        edge_cnt <= '0;
      end else if (en) begin
        edge_cnt <= bit_end ? '0 : edge_cnt + ONE;
      end
      // Three samples straddle the bit centre; the vote is settled by P/2+2.
      if (en) begin
        if (edge_cnt == half - ONE) smp[0] <= rx_s;
        if (edge_cnt == half)       smp[1] <= rx_s;
        if (edge_cnt == half + ONE) smp[2] <= rx_s;
      end
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver: sync, frame FSM, shift register, error flags
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int PRESC_W = 6
) (
  input logic     clk,
  input logic     rst,
  uart_rx_if.slave bus
);

  localparam int             BW       = $clog2(DATA_W);
  localparam logic [BW-1:0]  LAST_BIT = BW'(DATA_W - 1);

  rx_state_t          state, next_state;
  logic               rx_m, rx_s;
  logic [PRESC_W-1:0] p_q;
  logic               par_en_q, par_typ_q;
  logic [DATA_W-1:0]  shift;
  logic [BW-1:0]      bit_cnt;
  logic               par_bad;
  logic [DATA_W-1:0]  p_data_q;
  logic               data_valid_q, par_err_q, stp_err_q;
  logic               bit_val, bit_end;
  logic               start_det;

  assign start_det = (state == IDLE) && !rx_s;

  uart_rx_sampler #(.PRESC_W(PRESC_W)) u_sampler (
    .clk     (clk),
    .rst     (rst),
    .rx_s    (rx_s),
    .p       (p_q),
    .en      (state != IDLE),
    .restart (start_det),
    .bit_val (bit_val),
    .bit_end (bit_end)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m  <= 1'b1;
      rx_s  <= 1'b1;
      state <= IDLE;
    end else begin
      rx_m  <= bus.RX_IN;
      rx_s  <= rx_m;
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!rx_s) next_state = START;
      START:   if (bit_end) next_state = bit_val ? IDLE : DATA;
      DATA:    if (bit_end && (bit_cnt == LAST_BIT)) next_state = par_en_q ? PARITY : STOP;
      PARITY:  if (bit_end) next_state = STOP;
      STOP:    if (bit_end) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q          <= PRESC_W'(PRESC_8);
      par_en_q     <= 1'b0;
      par_typ_q    <= PAR_EVEN;
      shift        <= '0;
      bit_cnt      <= '0;
      par_bad      <= 1'b0;
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
      if (start_det) begin
        p_q       <= presc_ok(32'(bus.prescale)) ? bus.prescale : PRESC_W'(PRESC_8);
        par_en_q  <= bus.PAR_EN;
        par_typ_q <= bus.PAR_TYP;
        par_bad   <= 1'b0;
      end
      if ((state == START) && bit_end) bit_cnt <= '0;
      // LSB arrives first, so shifting in at the MSB leaves it in bit 0.
      if ((state == DATA) && bit_end) begin
        shift   <= {bit_val, shift[DATA_W-1:1]};
        bit_cnt <= bit_cnt + BW'(1);
      end
      if ((state == PARITY) && bit_end)
        par_bad <= (bit_val != ((^shift) ^ (par_typ_q == PAR_ODD)));
      if ((state == STOP) && bit_end) begin
        stp_err_q <= !bit_val;
        par_err_q <= par_bad;
        if (bit_val && !par_bad) begin
          p_data_q     <= shift;
          data_valid_q <= 1'b1;
        end
      end
    end
  end

  assign bus.P_DATA     = p_data_q;
  assign bus.data_valid = data_valid_q;
  assign bus.par_err    = par_err_q;
  assign bus.stp_err    = stp_err_q;
  assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed and randomized frames for uart_rx scored by a frame-level model
module tb_uart_rx;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_if #(.DATA_W(8), .PRESC_W(6)) bus ();

  uart_rx #(.DATA_W(8), .PRESC_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int dv_cnt = 0, pe_cnt = 0, se_cnt = 0, busy_cnt = 0;
  logic [7:0] dv_q[$];
  logic [7:0] model_pdata = 8'h00;

  always @(negedge clk) begin
    if (bus.data_valid) begin
      dv_cnt++;
      dv_q.push_back(bus.P_DATA);
    end
    if (bus.par_err) pe_cnt++;
    if (bus.stp_err) se_cnt++;
    if (bus.busy)    busy_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    bus.RX_IN = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame bit by bit; config inputs are scrambled after the start bit.
  task automatic send_frame(input logic [7:0] d, input int p, input logic [5:0] presc_in,
                            input logic pen, input logic ptyp, input logic bad_par,
                            input logic stop_val, input int glitch_bit, input int abort_bit);
    logic q[$];
    logic pb;
    bus.prescale = presc_in;
    bus.PAR_EN   = pen;
    bus.PAR_TYP  = ptyp;
    pb = 1'(($countones(d) + ((ptyp == PAR_ODD) ? 1 : 0)) % 2);
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(d[i]);
    if (pen) q.push_back(pb ^ bad_par);
    q.push_back(stop_val);
    for (int j = 0; j < q.size(); j++) begin
      if (j == abort_bit) begin
        rst       = 1'b1;
        bus.RX_IN = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        return;
      end
      for (int c = 0; c < p; c++) begin
        bus.RX_IN = q[j] ^ ((j == glitch_bit) && (c == p / 2 + 1));
        if (j == 1 && c == 0) begin
          bus.prescale = 6'(8 << $urandom_range(0, 2));
          bus.PAR_EN   = 1'($urandom_range(0, 1));
          bus.PAR_TYP  = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic frame_check(input string tag, input logic [7:0] d, input int p,
                             input logic [5:0] presc_in, input logic pen, input logic ptyp,
                             input logic bad_par, input logic stop_val, input int glitch_bit,
                             input int gap_bits);
    int dv0, pe0, se0;
    logic exp_ok;
    dv0 = dv_cnt;
    pe0 = pe_cnt;
    se0 = se_cnt;
    exp_ok = stop_val && !(pen && bad_par);
    send_frame(d, p, presc_in, pen, ptyp, bad_par, stop_val, glitch_bit, -1);
    idle(gap_bits * p + 4);
    if (exp_ok) model_pdata = d;
    check({tag, ".dv"},   32'(dv_cnt - dv0), 32'(exp_ok));
    check({tag, ".pe"},   32'(pe_cnt - pe0), 32'(pen && bad_par));
    check({tag, ".se"},   32'(se_cnt - se0), 32'(!stop_val));
    check({tag, ".data"}, 32'(bus.P_DATA),   32'(model_pdata));
    check({tag, ".busy"}, 32'(bus.busy),     32'(0));
  endtask

  initial begin
    int b0, dv0, pe0, se0;
    bus.RX_IN    = 1'b1;
    bus.prescale = 6'd8;
    bus.PAR_EN   = 1'b0;
    bus.PAR_TYP  = PAR_EVEN;
    repeat (4) @(negedge clk);
    check("rst.data",  32'(bus.P_DATA),     32'(0));
    check("rst.dv",    32'(bus.data_valid), 32'(0));
    check("rst.pe",    32'(bus.par_err),    32'(0));
    check("rst.se",    32'(bus.stp_err),    32'(0));
    check("rst.busy",  32'(bus.busy),       32'(0));
    rst = 1'b0;
    idle(10);

    b0 = busy_cnt;
    frame_check("a5_even", 8'hA5, 8, 6'd8, 1'b1, PAR_EVEN, 1'b0, 1'b1, -1, 1);
    check("a5_even.busy_len", 32'(busy_cnt - b0), 32'(88));

    frame_check("3c_oddbad", 8'h3C, 16, 6'd16, 1'b1, PAR_ODD, 1'b1, 1'b1, -1, 1);
    frame_check("81_stop0", 8'h81, 32, 6'd32, 1'b0, PAR_EVEN, 1'b0, 1'b0, -1, 2);
    frame_check("7e_ok", 8'h7E, 32, 6'd32, 1'b0, PAR_EVEN, 1'b0, 1'b1, -1, 1);

    // Short low pulse: the start bit votes high and the frame is dropped.
    dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt; b0 = busy_cnt;
    bus.prescale = 6'd16;
    bus.RX_IN = 1'b0;
    repeat (3) @(negedge clk);
    bus.RX_IN = 1'b1;
    repeat (16) @(negedge clk);
    check("glitch_start.busy", 32'(bus.busy), 32'(0));
    check("glitch_start.busy_len", 32'(busy_cnt - b0), 32'(16));
    idle(32);
    check("glitch_start.pulses", 32'((dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0)), 32'(0));

    frame_check("55_glitch", 8'h55, 8, 6'd8, 1'b0, PAR_EVEN, 1'b0, 1'b1, 4, 1);
    frame_check("5a_badpresc", 8'h5A, 8, 6'd20, 1'b1, PAR_ODD, 1'b0, 1'b1, -1, 1);

    for (int i = 0; i < 10; i++) begin
      logic [7:0] d;
      int p;
      d = 8'($urandom);
      p = 8 << $urandom_range(0, 2);
      frame_check($sformatf("rnd%0d", i), d, p, 6'(p), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) != 0, -1, 1 + $urandom_range(0, 1));
    end

    // Back-to-back frames, then a reset in the middle of a third one.
    dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
    send_frame(8'h12, 8, 6'd8, 1'b0, PAR_EVEN, 1'b0, 1'b1, -1, -1);
    send_frame(8'h34, 8, 6'd8, 1'b0, PAR_EVEN, 1'b0, 1'b1, -1, -1);
    send_frame(8'hC3, 8, 6'd8, 1'b0, PAR_EVEN, 1'b0, 1'b1, -1, 5);
    check("b2b.dv", 32'(dv_cnt - dv0), 32'(2));
    check("b2b.first", 32'(dv_q[dv_q.size() - 2]), 32'(8'h12));
    check("b2b.second", 32'(dv_q[dv_q.size() - 1]), 32'(8'h34));
    check("b2b.errs", 32'((pe_cnt - pe0) + (se_cnt - se0)), 32'(0));
    model_pdata = 8'h00;
    check("midrst.data", 32'(bus.P_DATA), 32'(model_pdata));
    check("midrst.busy", 32'(bus.busy), 32'(0));
    check("midrst.flags", 32'({bus.data_valid, bus.par_err, bus.stp_err}), 32'(0));
    dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
    idle(120);
    check("midrst.pulses", 32'((dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0)), 32'(0));
    check("midrst.data_hold", 32'(bus.P_DATA), 32'(model_pdata));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
